// File: rtl/usb_phy_rx.sv
// Full-speed USB receive front end: line synchroniser, 4x oversampled bit recovery,
// SYNC detect, NRZI decode, bit unstuffing, EOP and bus-reset detection.
`timescale 1ns/1ps
module usb_phy_rx #(
    parameter int OVERSAMPLE     = 4,
    parameter int STUFF_BITS_N   = 6,
    parameter int RST_SE0_CYCLES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_rx,
    input  logic       dn_rx,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    output logic       usb_reset
);
    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int UW = $clog2(STUFF_BITS_N + 1);
    localparam int TW = $clog2(RST_SE0_CYCLES + 1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [15:0] SYNC_PAT = {LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K};

    typedef enum logic [1:0] {IDLE, DATA, EOP, ERR} state_t;

    logic [1:0]    dp_sync, dn_sync;
    logic [1:0]    ls_q;
    logic [PW-1:0] phase_q, phase_eff;
    logic          bit_stb;
    logic [15:0]   hist, hist_next;
    logic [TW-1:0] se0_timer;

    state_t        state, state_n;
    logic [1:0]    prev, prev_n;
    logic [UW-1:0] unstuff, unstuff_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [1:0]    se0_cnt, se0_cnt_n;
    logic [2:0]    j_cnt, j_cnt_n;
    logic [7:0]    data_n;
    logic          valid_n, err_n, bit_val;

    // Synchronisers reset to J so the bus looks idle straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sync <= 2'b11;
            dn_sync <= 2'b00;
        end else begin
            dp_sync <= {dp_sync[0], dp_rx};
            dn_sync <= {dn_sync[0], dn_rx};
        end
    end

    assign line_state = {dn_sync[1], dp_sync[1]};

    // Any line change re-centres the sampling phase on the current cycle.
    assign phase_eff = (line_state != ls_q) ? '0 : phase_q;
    assign bit_stb   = (phase_eff == PW'(OVERSAMPLE / 2));
    assign hist_next = {hist[13:0], line_state};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_q      <= LS_J;
            phase_q   <= '0;
            hist      <= '0;
            se0_timer <= '0;
        end else begin
            ls_q    <= line_state;
            phase_q <= (phase_eff == PW'(OVERSAMPLE - 1)) ? '0 : phase_eff + PW'(1);
            if (bit_stb)
                hist <= hist_next;
            if (line_state != LS_SE0)
                se0_timer <= '0;
            else if (se0_timer != TW'(RST_SE0_CYCLES))
                se0_timer <= se0_timer + TW'(1);
        end
    end

    assign usb_reset = (se0_timer == TW'(RST_SE0_CYCLES));
    assign rx_active = (state == DATA) || (state == EOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= LS_J;
            unstuff  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            se0_cnt  <= '0;
            j_cnt    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_n;
            prev     <= prev_n;
            unstuff  <= unstuff_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            se0_cnt  <= se0_cnt_n;
            j_cnt    <= j_cnt_n;
            rx_data  <= data_n;
            rx_valid <= valid_n;
            rx_err   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        prev_n    = prev;
        unstuff_n = unstuff;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        se0_cnt_n = se0_cnt;
        j_cnt_n   = j_cnt;
        data_n    = rx_data;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        bit_val   = (line_state == prev);

        // A bus reset silently abandons any packet in flight.
        if (usb_reset && (state == DATA || state == EOP)) begin
            state_n = IDLE;
        end else if (bit_stb) begin
            case (state)
                IDLE: begin
                    if (hist_next == SYNC_PAT) begin
                        state_n   = DATA;
                        prev_n    = LS_K;
                        unstuff_n = UW'(1);
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    if (line_state == LS_SE0) begin
                        state_n   = EOP;
                        se0_cnt_n = 2'd1;
                    end else if (line_state == LS_SE1) begin
                        err_n   = 1'b1;
                        state_n = ERR;
                        j_cnt_n = '0;
                    end else begin
                        prev_n = line_state;
                        if (unstuff == UW'(STUFF_BITS_N)) begin
                            // Stuffed bit: must be a transition, carries no data.
                            if (line_state == prev) begin
                                err_n   = 1'b1;
                                state_n = ERR;
                                j_cnt_n = '0;
                            end
                            unstuff_n = '0;
                        end else begin
                            unstuff_n = bit_val ? unstuff + UW'(1) : '0;
                            shift_n   = {bit_val, shift[7:1]};
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                valid_n = 1'b1;
                                data_n  = {bit_val, shift[7:1]};
                            end
                        end
                    end
                end
                EOP: begin
                    if (line_state == LS_SE0 && se0_cnt < 2'd2) begin
                        se0_cnt_n = se0_cnt + 2'd1;
                    end else if (line_state == LS_J) begin
                        state_n = IDLE;
                        err_n   = (bit_cnt != 3'd0);
                    end else begin
                        err_n   = 1'b1;
                        state_n = ERR;
                        j_cnt_n = '0;
                    end
                end
                ERR: begin
                    if (line_state == LS_J) begin
                        if (j_cnt == 3'd7)
                            state_n = IDLE;
                        j_cnt_n = j_cnt + 3'd1;
                    end else begin
                        j_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_phy_rx.sv
// Bench for usb_phy_rx: NRZI/stuffing host encoder, expected-byte queue and
// per-cycle comparison of line_state, usb_reset, rx_data and strobes.
`timescale 1ns/1ps
module tb_usb_phy_rx;
    localparam real        BIT_NS = 80.0;
    localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10;

    logic       clk = 1'b0, rst = 1'b1, dp_rx = 1'b1, dn_rx = 1'b0;
    logic [1:0] line_state;
    logic       rx_active, rx_valid, rx_err, usb_reset;
    logic [7:0] rx_data;

    usb_phy_rx dut (
        .clk(clk), .rst(rst), .dp_rx(dp_rx), .dn_rx(dn_rx),
        .line_state(line_state), .rx_active(rx_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_err(rx_err), .usb_reset(usb_reset)
    );

    always #10 clk = ~clk;

    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];
    logic [1:0] sym_log[$];
    int         err_allowed = 0, valid_cnt = 0, err_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    logic [1:0] m1 = J, m2 = J;
    int         se0_run = 0;
    real        t_nom = 0.0;
    bit         jitter_en = 1'b0;
    logic [1:0] cur = J;
    int         ones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- host line driver ----------------
    task automatic bit_out(input logic [1:0] ls);
        real j, d;
        j = jitter_en ? (real'($urandom_range(0, 200)) - 100.0) / 1000.0 : 0.0;
        d = t_nom + j - $realtime;
        if (d > 0.0) #(d);
        {dn_rx, dp_rx} = ls;
        sym_log.push_back(ls);
        t_nom = t_nom + BIT_NS;
    endtask

    task automatic nrzi_bit(input logic b);
        if (!b) cur = (cur == J) ? K : J;
        bit_out(cur);
    endtask

    task automatic data_bit(input logic b);
        nrzi_bit(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                nrzi_bit(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_sync();
        cur = J;
        repeat (7) nrzi_bit(1'b0);
        nrzi_bit(1'b1);
        ones = 1;
    endtask

    task automatic send_eop();
        bit_out(SE0);
        bit_out(SE0);
        bit_out(J);
        cur = J;
    endtask

    task automatic idle(input int n);
        repeat (n) bit_out(J);
        cur = J;
    endtask

    task automatic send_packet();
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        send_sync();
        foreach (pkt[i])
            for (int b = 0; b < 8; b++) data_bit(pkt[i][b]);
        send_eop();
        idle(10);
    endtask

    task automatic end_check(input string name);
        chk({name, "_bytes_pending"}, exp_q.size(), 0);
        chk({name, "_errs_missing"}, err_allowed, 0);
        exp_q.delete();
        err_allowed = 0;
    endtask

    // ---------------- reference model and compare ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = J;
            m2 = J;
        end else begin
            m2 = m1;
            m1 = {dn_rx, dp_rx};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_line_state", line_state, J);
            chk("rst_outputs", {rx_active, rx_valid, rx_err, usb_reset, rx_data}, 0);
            last_byte = 8'h00;
            se0_run   = 0;
        end else begin
            chk("line_state", line_state, m2);
            chk("usb_reset", usb_reset, (se0_run >= 120));
            se0_run = (m2 == SE0) ? ((se0_run < 100000) ? se0_run + 1 : se0_run) : 0;
            if (rx_valid) begin
                valid_cnt++;
                chk("rx_valid_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    last_byte = exp_q.pop_front();
                    chk("rx_data", rx_data, last_byte);
                end
            end else begin
                chk("rx_data_hold", rx_data, last_byte);
            end
            if (rx_err) begin
                err_cnt++;
                chk("rx_err_expected", (err_allowed > 0), 1);
                if (err_allowed > 0) err_allowed--;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] packed_syms;
        logic [9:0]  ten_bits;
        int          v0, e0, n;

        repeat (3) @(negedge clk);
        chk("reset_line_state", line_state, J);
        chk("reset_rx_active", rx_active, 0);
        chk("reset_usb_reset", usb_reset, 0);
        rst = 1'b0;
        @(negedge clk);
        t_nom = $realtime;
        idle(4);

        // ACK: exactly one byte, encoder symbols pinned by hand
        pkt = '{8'hD2};
        sym_log.delete();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_packet();
        packed_syms = '0;
        for (int i = 0; i < 16; i++) packed_syms = {packed_syms[29:0], sym_log[i]};
        chk("ack_line_symbols", packed_syms, 32'h999A_596A);
        chk("ack_valid_count", valid_cnt - v0, 1);
        chk("ack_err_count", err_cnt - e0, 0);
        chk("ack_rx_active_after_eop", rx_active, 0);
        end_check("ack");

        // Stuffing: three stuffed bits expected in C3 FF FF 00
        pkt = '{8'hC3, 8'hFF, 8'hFF, 8'h00};
        sym_log.delete();
        v0 = valid_cnt;
        send_packet();
        chk("stuffed_symbol_count", sym_log.size(), 56);
        chk("stuffed_valid_count", valid_cnt - v0, 4);
        end_check("stuff");

        // Stuff error: seven identical states after SYNC
        v0 = valid_cnt;
        e0 = err_cnt;
        err_allowed = 1;
        send_sync();
        repeat (7) bit_out(K);
        idle(2);
        chk("stufferr_rx_active", rx_active, 0);
        idle(10);
        chk("stufferr_err_count", err_cnt - e0, 1);
        chk("stufferr_no_valid", valid_cnt - v0, 0);
        end_check("stufferr");
        pkt = '{8'hD2};
        send_packet();
        chk("after_err_ack_valid", valid_cnt - v0, 1);
        end_check("after_err");

        // Partial byte: ten bits then EOP
        ten_bits = 10'($urandom);
        v0 = valid_cnt;
        e0 = err_cnt;
        exp_q.push_back(ten_bits[7:0]);
        err_allowed = 1;
        send_sync();
        for (int i = 0; i < 10; i++) data_bit(ten_bits[i]);
        send_eop();
        idle(10);
        chk("partial_valid_count", valid_cnt - v0, 1);
        chk("partial_err_count", err_cnt - e0, 1);
        end_check("partial");

        // Bus reset: SE0 held for 300 clk
        fork
            begin
                repeat (75) bit_out(SE0);
                idle(10);
            end
            begin
                n = 0;
                while (line_state != SE0 && n < 400) begin @(negedge clk); n++; end
                chk("busrst_se0_seen", line_state, SE0);
                n = 0;
                while (!usb_reset && n < 200) begin @(negedge clk); n++; end
                chk("busrst_latency", n, 120);
                n = 0;
                while (line_state != J && n < 400) begin @(negedge clk); n++; end
                chk("busrst_high_at_j", usb_reset, 1);
                @(negedge clk);
                chk("busrst_drop", usb_reset, 0);
            end
        join
        end_check("busrst");

        // Async reset mid-packet
        send_sync();
        data_bit(1'b1); data_bit(1'b0); data_bit(1'b1); data_bit(1'b0);
        chk("midpkt_rx_active", rx_active, 1);
        #2;
        rst = 1'b1;
        idle(3);
        chk("inrst_rx_active", rx_active, 0);
        chk("inrst_rx_data", rx_data, 0);
        chk("inrst_line_state", line_state, J);
        #2;
        rst = 1'b0;
        idle(10);
        v0 = valid_cnt;
        pkt = '{8'h4B};
        send_packet();
        chk("postrst_valid_count", valid_cnt - v0, 1);
        end_check("postrst");

        // Jittered traffic
        jitter_en = 1'b1;
        e0 = err_cnt;
        pkt = '{8'h4B};
        send_packet();
        for (int r = 0; r < 10; r++) begin
            pkt.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            send_packet();
        end
        chk("jitter_err_count", err_cnt - e0, 0);
        end_check("jitter");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
